stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
Multi-cycle instruction sequencer for the single-cycle-per-stage core. It issues one-cycle start pulses to the IF, EX, MEM and WB stages and waits for each stage's kick_up done pulse. It routes each instruction through only the stages it needs, using the decoder's Controller_* outputs. It also provides single-step/halt control, a per-stage watchdog timeout and a retired-instruction counter.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent waiting in any wait state before a watchdog error; legal range 1..255.
CNT_W, 32, width of instr_count.

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  level-sampled; begins or resumes execution from IDLE or HALTED
halt_req  input  1  request to stop at the next instruction boundary
fetch_start  output  1  one-cycle pulse to the IF stage
IF_kick_up  input  1  IF done pulse (instruction valid); the same net drives the decoder
Controller_kick_up  input  1  decoder done pulse
Controller_memread  input  1  decoder control, held stable after Controller_kick_up
Controller_memwrite  input  1  decoder control
Controller_regwrite  input  1  decoder control
Controller_branch  input  1  decoder control
EX_start  output  1  one-cycle pulse to the EX stage
EX_kick_up  input  1  EX done pulse
MEM_start  output  1  one-cycle pulse to the MEM stage
MEM_kick_up  input  1  MEM done pulse
WB_start  output  1  one-cycle pulse to the WB stage
WB_kick_up  input  1  WB done pulse
pc_advance  output  1  one-cycle pulse at instruction retirement
pc_branch  output  1  latched Controller_branch; valid only while pc_advance=1, otherwise 0
busy  output  1  1 in every state except IDLE and HALTED
timeout_err  output  1  sticky watchdog flag
instr_count  output  CNT_W  retired-instruction count
state  output  3  encoded current state

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - All outputs 0, instr_count=0, timeout_err=0.
  - halt_pending=0, control latches=0, wait counter=0.
  - A reset asserted mid-instruction aborts the instruction immediately; no pc_advance is issued.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, NEXT=6, HALTED=7.
- All outputs are registered. Each *_start pulse is high for exactly the first cycle spent in its state.
- State transitions:
  - IDLE: start=1 -> FETCH. If halt_req=1 in the same cycle, halt_pending is set, giving a single step.
  - FETCH (fetch_start pulse): IF_kick_up -> DECODE.
  - DECODE: Controller_kick_up -> EXEC. In that same cycle, latch memread, memwrite, regwrite and branch.
  - EXEC (EX_start pulse): on EX_kick_up, go to MEM if (memread|memwrite); else WB if regwrite; else NEXT.
  - MEM (MEM_start pulse): MEM_kick_up -> WB if regwrite, else NEXT.
  - WB (WB_start pulse): WB_kick_up -> NEXT.
  - NEXT: lasts one cycle. pc_advance=1, pc_branch=latched branch, instr_count+1 (wraps modulo 2^CNT_W). Then -> HALTED if halt_pending, else FETCH.
  - HALTED: start=1 -> FETCH and clears halt_pending; halt_req in the same cycle re-sets it. timeout_err is not cleared.
- halt_req:
  - Sampled in every state except HALTED; sets sticky halt_pending.
  - It never interrupts an instruction in progress.
  - In IDLE without start, it is ignored.
- Done pulses:
  - A done pulse is honoured only in the state waiting for it.
  - A done pulse arriving in any other state is ignored and not remembered.
- Watchdog:
  - The wait counter clears on entry to FETCH, DECODE, EXEC, MEM or WB, and counts every cycle spent in that state, starting with the entry cycle as 1.
  - If the expected done pulse has not arrived by cycle TIMEOUT_CYCLES, the next edge goes to HALTED and sets timeout_err.
  - A done pulse arriving on cycle TIMEOUT_CYCLES is honoured; no error is raised.
  - No instr_count increment and no pc_advance occur on timeout.
- Latency with each done returned the cycle after its start: an ALU-register instruction takes 9 cycles from the first FETCH cycle to the NEXT cycle, inclusive.
- busy is combinationally derived from the registered state: busy=0 in IDLE and HALTED, 1 otherwise.

Test Plan:
1. Reset, then start=1 for one cycle. R-type instruction (regwrite=1, mem=0), each done returned 1 cycle after its start -> state sequence 1,2,3,5,6,1. MEM_start is never asserted, pc_advance pulses once, instr_count=1, pc_branch=0.
2. Load (memread=1, regwrite=1), then store (memwrite=1, regwrite=0), then beq (branch=1, all others 0) -> paths are EXEC->MEM->WB->NEXT; EXEC->MEM->NEXT; EXEC->NEXT with pc_branch=1. instr_count=3.
3. Single step: start and halt_req together in IDLE -> one instruction retires, then state=7 and busy=0. A second start pulse retires exactly one more instruction only if halt_req is reasserted.
4. TIMEOUT_CYCLES=4, EX_kick_up withheld -> EXEC lasts 4 cycles, then state=7 and timeout_err=1, instr_count unchanged. Repeat with EX_kick_up on the 4th EXEC cycle -> no error; the next state follows the routing rules.
5. Spurious pulses: EX_kick_up and WB_kick_up pulsed while in FETCH -> ignored. The bench then holds EX_kick_up and WB_kick_up low in EXEC and WB; EXEC still waits for its own EX_kick_up and WB still waits for its own WB_kick_up.
6. Reset deasserted then reasserted low mid-MEM -> immediately state=0, all outputs 0, instr_count=0. Start after release -> a clean fetch with a fetch_start pulse.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: pulses each pipeline stage in turn, waits for its done
// pulse, routes by decoded controls, and provides single-step/halt, watchdog and retire count.
module stage_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             fetch_start,
  input  logic             IF_kick_up,
  input  logic             Controller_kick_up,
  input  logic             Controller_memread,
  input  logic             Controller_memwrite,
  input  logic             Controller_regwrite,
  input  logic             Controller_branch,
  output logic             EX_start,
  input  logic             EX_kick_up,
  output logic             MEM_start,
  input  logic             MEM_kick_up,
  output logic             WB_start,
  input  logic             WB_kick_up,
  output logic             pc_advance,
  output logic             pc_branch,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StNext   = 3'd6,
    StHalted = 3'd7
  } state_e;

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  state_e           state_q;
  state_e           wait_next;
  logic             wait_done;
  logic [7:0]       wait_cnt_q;
  logic             halt_pending_q;
  logic             memread_q;
  logic             memwrite_q;
  logic             regwrite_q;
  logic             branch_q;
  logic             timeout_q;
  logic [CNT_W-1:0] instr_count_q;

  // Done pulse being waited for in the current state, and where it leads.
  always_comb begin
    wait_done = 1'b0;
    wait_next = StIdle;
    unique case (state_q)
      StFetch: begin
        wait_done = IF_kick_up;
        wait_next = StDecode;
      end
      StDecode: begin
        wait_done = Controller_kick_up;
        wait_next = StExec;
      end
      StExec: begin
        wait_done = EX_kick_up;
        if (memread_q || memwrite_q) begin
          wait_next = StMem;
        end else if (regwrite_q) begin
          wait_next = StWb;
        end else begin
          wait_next = StNext;
        end
      end
      StMem: begin
        wait_done = MEM_kick_up;
        wait_next = regwrite_q ? StWb : StNext;
      end
      StWb: begin
        wait_done = WB_kick_up;
        wait_next = StNext;
      end
      default: begin
        wait_done = 1'b0;
        wait_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      wait_cnt_q     <= 8'd0;
      halt_pending_q <= 1'b0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      branch_q       <= 1'b0;
      timeout_q      <= 1'b0;
      instr_count_q  <= '0;
      fetch_start    <= 1'b0;
      EX_start       <= 1'b0;
      MEM_start      <= 1'b0;
      WB_start       <= 1'b0;
      pc_advance     <= 1'b0;
      pc_branch      <= 1'b0;
    end else begin
      fetch_start <= 1'b0;
      EX_start    <= 1'b0;
      MEM_start   <= 1'b0;
      WB_start    <= 1'b0;
      pc_advance  <= 1'b0;
      pc_branch   <= 1'b0;
      unique case (state_q)
        StIdle, StHalted: begin
          // halt_req alongside start arms a single step; a bare halt_req here is dropped.
          if (start) begin
            state_q        <= StFetch;
            fetch_start    <= 1'b1;
            wait_cnt_q     <= 8'd1;
            halt_pending_q <= halt_req;
          end
        end
        StNext: begin
          if (halt_pending_q || halt_req) begin
            state_q        <= StHalted;
            halt_pending_q <= 1'b1;
            wait_cnt_q     <= 8'd0;
          end else begin
            state_q     <= StFetch;
            fetch_start <= 1'b1;
            wait_cnt_q  <= 8'd1;
          end
        end
        default: begin
          if (halt_req) begin
            halt_pending_q <= 1'b1;
          end
          if (wait_done) begin
            state_q    <= wait_next;
            wait_cnt_q <= (wait_next == StNext) ? 8'd0 : 8'd1;
            if (state_q == StDecode) begin
              memread_q  <= Controller_memread;
              memwrite_q <= Controller_memwrite;
              regwrite_q <= Controller_regwrite;
              branch_q   <= Controller_branch;
            end
            case (wait_next)
              StExec: EX_start  <= 1'b1;
              StMem:  MEM_start <= 1'b1;
              StWb:   WB_start  <= 1'b1;
              StNext: begin
                pc_advance    <= 1'b1;
                pc_branch     <= branch_q;
                instr_count_q <= instr_count_q + CNT_W'(1);
              end
              default: ;
            endcase
          end else if (wait_cnt_q >= TimeoutLimit) begin
            // Watchdog: abandon the instruction without retiring it.
            state_q    <= StHalted;
            timeout_q  <= 1'b1;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StHalted);
  assign timeout_err = timeout_q;
  assign instr_count = instr_count_q;
  assign state       = state_q;

endmodule
